// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one registered memory port among NCH requesters.
// Round-robin fairness, one ready pulse per transaction, and an optional
// wait-state timeout that completes the transaction with an error flag.

module mem_arbiter #(
  parameter int NCH     = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 0
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic [NCH-1:0]    iReqRead,
  input  logic [NCH-1:0]    iReqWrite,
  input  logic [NCH*AW-1:0] iReqAddr,
  input  logic [NCH*DW-1:0] iReqData,
  output logic [DW-1:0]     oReqData,
  output logic [NCH-1:0]    oReqRdy,
  output logic [NCH-1:0]    oReqErr,
  output logic [NCH-1:0]    oGrant,
  output logic              oBusy,
  output logic [AW-1:0]     oMemAddr,
  output logic [DW-1:0]     oMemData,
  output logic              oMemRead,
  output logic              oMemWrite,
  input  logic [DW-1:0]     iMemData,
  input  logic              iMemRdy
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CntLast = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [PW-1:0] LastCh  = PW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state_q;
  logic [PW-1:0]   rr_q;
  logic [PW-1:0]   g_q;
  logic [CW-1:0]   cnt_q;
  logic [NCH-1:0]  grant_q;
  logic [NCH-1:0]  reqRdy_q;
  logic [NCH-1:0]  reqErr_q;
  logic            busy_q;
  logic            memRead_q;
  logic            memWrite_q;
  logic [AW-1:0]   memAddr_q;
  logic [DW-1:0]   memData_q;
  logic [DW-1:0]   reqData_q;

  logic [NCH-1:0]  req_d;
  logic            hiFound_d;
  logic            loFound_d;
  logic [PW-1:0]   hiIdx_d;
  logic [PW-1:0]   loIdx_d;
  logic            winValid_d;
  logic [PW-1:0]   win_d;
  logic [AW-1:0]   winAddr_d;
  logic [DW-1:0]   winData_d;
  logic            winWrite_d;
  logic [NCH-1:0]  winOneHot_d;

  // Winner is the first requester at or above the pointer; if none, wrap to the lowest requester
  always_comb begin
    req_d     = iReqRead | iReqWrite;
    hiFound_d = 1'b0;
    loFound_d = 1'b0;
    hiIdx_d   = '0;
    loIdx_d   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!hiFound_d && req_d[i] && (PW'(i) >= rr_q)) begin
        hiFound_d = 1'b1;
        hiIdx_d   = PW'(i);
      end
      if (!loFound_d && req_d[i]) begin
        loFound_d = 1'b1;
        loIdx_d   = PW'(i);
      end
    end
    winValid_d = loFound_d;
    win_d      = hiFound_d ? hiIdx_d : loIdx_d;
  end

  // Select the winning channel's address, write data and operation (write beats read)
  always_comb begin
    winAddr_d   = '0;
    winData_d   = '0;
    winWrite_d  = 1'b0;
    winOneHot_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (PW'(i) == win_d) begin
        winAddr_d      = iReqAddr[i*AW +: AW];
        winData_d      = iReqData[i*DW +: DW];
        winWrite_d     = iReqWrite[i];
        winOneHot_d[i] = 1'b1;
      end
    end
  end

  // Arbitration FSM with all memory-side and requester-side outputs registered
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      g_q        <= '0;
      cnt_q      <= '0;
      grant_q    <= '0;
      reqRdy_q   <= '0;
      reqErr_q   <= '0;
      busy_q     <= 1'b0;
      memRead_q  <= 1'b0;
      memWrite_q <= 1'b0;
      memAddr_q  <= '0;
      memData_q  <= '0;
      reqData_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (winValid_d) begin
            g_q        <= win_d;
            grant_q    <= winOneHot_d;
            busy_q     <= 1'b1;
            memAddr_q  <= winAddr_d;
            memData_q  <= winData_d;
            memWrite_q <= winWrite_d;
            memRead_q  <= !winWrite_d;
            cnt_q      <= '0;
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          if (iMemRdy) begin
            memRead_q  <= 1'b0;
            memWrite_q <= 1'b0;
            reqRdy_q   <= grant_q;
            reqErr_q   <= '0;
            if (memRead_q) begin
              reqData_q <= iMemData;
            end
            state_q    <= RESP;
          end else if ((TIMEOUT > 0) && (cnt_q == CntLast)) begin
            memRead_q  <= 1'b0;
            memWrite_q <= 1'b0;
            reqRdy_q   <= grant_q;
            reqErr_q   <= grant_q;
            reqData_q  <= '0;
            state_q    <= RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RESP: begin
          reqRdy_q <= '0;
          reqErr_q <= '0;
          grant_q  <= '0;
          busy_q   <= 1'b0;
          if (g_q == LastCh) begin
            rr_q <= '0;
          end else begin
            rr_q <= g_q + PW'(1);
          end
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign oReqData  = reqData_q;
  assign oReqRdy   = reqRdy_q;
  assign oReqErr   = reqErr_q;
  assign oGrant    = grant_q;
  assign oBusy     = busy_q;
  assign oMemAddr  = memAddr_q;
  assign oMemData  = memData_q;
  assign oMemRead  = memRead_q;
  assign oMemWrite = memWrite_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized run checked against a
// transaction-level model of the arbiter (round-robin pointer, wait states,
// timeout and held read data).

module tb_mem_arbiter;

  localparam int NCH = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TO  = 8;

  logic              iClk;
  logic              iRst;
  logic [NCH-1:0]    iReqRead;
  logic [NCH-1:0]    iReqWrite;
  logic [NCH*AW-1:0] iReqAddr;
  logic [NCH*DW-1:0] iReqData;
  logic [DW-1:0]     oReqData;
  logic [NCH-1:0]    oReqRdy;
  logic [NCH-1:0]    oReqErr;
  logic [NCH-1:0]    oGrant;
  logic              oBusy;
  logic [AW-1:0]     oMemAddr;
  logic [DW-1:0]     oMemData;
  logic              oMemRead;
  logic              oMemWrite;
  logic [DW-1:0]     iMemData;
  logic              iMemRdy;

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;
  logic [DW-1:0] lastData;

  mem_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .iClk(iClk), .iRst(iRst),
    .iReqRead(iReqRead), .iReqWrite(iReqWrite),
    .iReqAddr(iReqAddr), .iReqData(iReqData),
    .oReqData(oReqData), .oReqRdy(oReqRdy), .oReqErr(oReqErr),
    .oGrant(oGrant), .oBusy(oBusy),
    .oMemAddr(oMemAddr), .oMemData(oMemData),
    .oMemRead(oMemRead), .oMemWrite(oMemWrite),
    .iMemData(iMemData), .iMemRdy(iMemRdy)
  );

  // Free-running clock
  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  // Hard time limit so a stuck run still ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "[TB] time limit reached");
  end

  // Advance one clock; outputs are then stable for the new cycle
  task automatic step();
    @(posedge iClk);
    #1;
    cyc++;
  endtask

  task automatic clearInputs();
    iReqRead  = '0;
    iReqWrite = '0;
    iReqAddr  = '0;
    iReqData  = '0;
    iMemData  = '0;
    iMemRdy   = 1'b0;
  endtask

  task automatic applyReset();
    clearInputs();
    iRst = 1'b1;
    step();
    iRst = 1'b0;
    lastData = '0;
  endtask

  task automatic test_reset();
    iReqRead = '1;
    iMemRdy  = 1'b1;
    iMemData = 32'hFFFF_FFFF;
    iReqAddr = '1;
    iRst = 1'b1;
    step();
    step();
    nChecks++;
    if ({oMemRead, oMemWrite, oBusy, oGrant, oReqRdy, oReqErr} !== '0) begin
      nFails++;
      $display("[TB] FAIL reset_ctrl: got rd=%b wr=%b busy=%b grant=%b rdy=%b err=%b, expected all 0",
               oMemRead, oMemWrite, oBusy, oGrant, oReqRdy, oReqErr);
    end
    nChecks++;
    if ({oMemAddr, oMemData, oReqData} !== '0) begin
      nFails++;
      $display("[TB] FAIL reset_data: got addr=%h wdata=%h rdata=%h, expected 0", oMemAddr, oMemData, oReqData);
    end
    iRst = 1'b0;
    clearInputs();
    lastData = '0;
  endtask

  task automatic test_single_read();
    iReqRead = 4'b0001;
    iReqAddr[0 +: AW] = 32'h100;
    step();
    nChecks++;
    if ({oMemRead, oMemWrite} !== 2'b10 || oMemAddr !== 32'h100 || oGrant !== 4'b0001) begin
      nFails++;
      $display("[TB] FAIL single_access: got rd=%b wr=%b addr=%h grant=%b, expected 1 0 00000100 0001",
               oMemRead, oMemWrite, oMemAddr, oGrant);
    end
    iMemRdy  = 1'b1;
    iMemData = 32'hDEAD_BEEF;
    step();
    iMemRdy  = 1'b0;
    iMemData = '0;
    nChecks++;
    if (oReqRdy !== 4'b0001 || oReqErr !== 4'b0000 || oReqData !== 32'hDEAD_BEEF) begin
      nFails++;
      $display("[TB] FAIL single_resp: got rdy=%b err=%b data=%h, expected 0001 0000 deadbeef", oReqRdy, oReqErr, oReqData);
    end
    nChecks++;
    if ({oMemRead, oMemWrite} !== 2'b00) begin
      nFails++;
      $display("[TB] FAIL single_strobe_drop: got rd=%b wr=%b, expected 0 0", oMemRead, oMemWrite);
    end
    iReqRead = '0;
    step();
    nChecks++;
    if (oReqRdy !== 4'b0000 || oBusy !== 1'b0 || oReqData !== 32'hDEAD_BEEF) begin
      nFails++;
      $display("[TB] FAIL single_idle: got rdy=%b busy=%b data=%h, expected 0000 0 deadbeef", oReqRdy, oBusy, oReqData);
    end
    lastData = 32'hDEAD_BEEF;
  endtask

  task automatic test_round_robin();
    int rrM, exp, idx, prevRdy;
    logic [DW-1:0] d;
    applyReset();
    rrM = 0;
    prevRdy = 0;
    iReqRead = 4'b0011;
    iReqAddr[0 +: AW]  = 32'hA0;
    iReqAddr[AW +: AW] = 32'hB0;
    iMemRdy = 1'b1;
    for (int t = 0; t < 4; t++) begin
      exp = -1;
      for (int i = 0; i < NCH; i++) begin
        idx = (rrM + i) % NCH;
        if (exp < 0 && iReqRead[idx]) exp = idx;
      end
      step();
      nChecks++;
      if (oGrant !== (NCH'(1) << exp) || oMemAddr !== ((exp == 0) ? 32'hA0 : 32'hB0)) begin
        nFails++;
        $display("[TB] FAIL rr_grant t=%0d: got grant=%b addr=%h, expected channel %0d", t, oGrant, oMemAddr, exp);
      end
      d = $urandom;
      iMemData = d;
      step();
      nChecks++;
      if (oReqRdy !== (NCH'(1) << exp) || oReqData !== d) begin
        nFails++;
        $display("[TB] FAIL rr_resp t=%0d: got rdy=%b data=%h, expected channel %0d data %h", t, oReqRdy, oReqData, exp, d);
      end
      if (t > 0) begin
        nChecks++;
        if (cyc - prevRdy !== 3) begin
          nFails++;
          $display("[TB] FAIL rr_spacing t=%0d: got %0d cycles between pulses, expected 3", t, cyc - prevRdy);
        end
      end
      prevRdy = cyc;
      lastData = d;
      iReqRead[exp] = 1'b0;
      rrM = (exp + 1) % NCH;
      step();
      iReqRead[exp] = 1'b1;
    end
    iReqRead = '0;
    iMemRdy  = 1'b0;
  endtask

  task automatic test_write_priority();
    int wrCycles, rdCycles;
    wrCycles = 0;
    rdCycles = 0;
    iReqRead[1]  = 1'b1;
    iReqWrite[1] = 1'b1;
    iReqAddr[AW +: AW] = 32'h20;
    iReqData[DW +: DW] = 32'h5A;
    iMemData = 32'hCAFE_0000;
    for (int j = 0; j < 5; j++) begin
      step();
      if (oMemWrite === 1'b1) wrCycles++;
      if (oMemRead === 1'b1) rdCycles++;
      nChecks++;
      if (oMemAddr !== 32'h20 || oMemData !== 32'h5A) begin
        nFails++;
        $display("[TB] FAIL wp_latched j=%0d: got addr=%h wdata=%h, expected 00000020 0000005a", j, oMemAddr, oMemData);
      end
      if (j == 1) begin
        iReqAddr[AW +: AW] = 32'hFFFF_0000;
        iReqData[DW +: DW] = 32'h77;
      end
      iMemRdy = (j == 4);
    end
    step();
    iMemRdy = 1'b0;
    nChecks++;
    if (wrCycles !== 5 || rdCycles !== 0 || oMemWrite !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL wp_strobes: got write cycles=%0d read cycles=%0d wr_now=%b, expected 5 0 0", wrCycles, rdCycles, oMemWrite);
    end
    nChecks++;
    if (oReqRdy !== 4'b0010 || oReqErr !== 4'b0000 || oReqData !== lastData) begin
      nFails++;
      $display("[TB] FAIL wp_resp: got rdy=%b err=%b data=%h, expected 0010 0000 %h", oReqRdy, oReqErr, oReqData, lastData);
    end
    iReqRead  = '0;
    iReqWrite = '0;
    step();
    nChecks++;
    if (oReqRdy !== 4'b0000) begin
      nFails++;
      $display("[TB] FAIL wp_single_pulse: got rdy=%b, expected 0000", oReqRdy);
    end
  endtask

  task automatic test_timeout();
    int hi;
    for (int pass = 0; pass < 2; pass++) begin
      hi = 0;
      iReqRead = 4'b0010;
      iReqAddr[AW +: AW] = 32'h300;
      iMemData = 32'hFFFF_FFFF;
      for (int j = 0; j < TO; j++) begin
        step();
        if (oMemRead === 1'b1) hi++;
        iMemRdy = (pass == 1) && (j == TO - 1);
        iMemData = (pass == 1) ? 32'h1234_5678 : 32'hFFFF_FFFF;
      end
      step();
      iMemRdy = 1'b0;
      nChecks++;
      if (hi !== TO || oMemRead !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL to_strobe pass=%0d: got %0d high cycles rd_now=%b, expected %0d 0", pass, hi, oMemRead, TO);
      end
      nChecks++;
      if (oReqRdy !== 4'b0010 || oReqErr !== ((pass == 0) ? 4'b0010 : 4'b0000)
          || oReqData !== ((pass == 0) ? 32'h0 : 32'h1234_5678)) begin
        nFails++;
        $display("[TB] FAIL to_resp pass=%0d: got rdy=%b err=%b data=%h", pass, oReqRdy, oReqErr, oReqData);
      end
      iReqRead = '0;
      step();
      lastData = (pass == 0) ? 32'h0 : 32'h1234_5678;
    end
  endtask

  task automatic test_reset_mid_access();
    int rdySeen;
    logic [DW-1:0] d;
    iReqRead = 4'b0010;
    iReqAddr[AW +: AW] = 32'h444;
    step();
    step();
    iRst = 1'b1;
    step();
    iRst = 1'b0;
    iReqRead = '0;
    nChecks++;
    if ({oMemRead, oMemWrite, oBusy, oGrant, oReqRdy, oReqErr} !== '0 || {oMemAddr, oMemData, oReqData} !== '0) begin
      nFails++;
      $display("[TB] FAIL rst_mid_outputs: got rd=%b wr=%b busy=%b grant=%b rdy=%b addr=%h rdata=%h, expected all 0",
               oMemRead, oMemWrite, oBusy, oGrant, oReqRdy, oMemAddr, oReqData);
    end
    rdySeen = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (oReqRdy !== 4'b0000) rdySeen++;
    end
    nChecks++;
    if (rdySeen !== 0) begin
      nFails++;
      $display("[TB] FAIL rst_mid_no_rdy: got %0d ready cycles, expected 0", rdySeen);
    end
    iReqRead = 4'b0101;
    step();
    nChecks++;
    if (oGrant !== 4'b0001) begin
      nFails++;
      $display("[TB] FAIL rst_mid_rr: got grant=%b, expected 0001", oGrant);
    end
    d = $urandom;
    iMemRdy  = 1'b1;
    iMemData = d;
    step();
    iMemRdy  = 1'b0;
    iReqRead = '0;
    nChecks++;
    if (oReqRdy !== 4'b0001 || oReqData !== d) begin
      nFails++;
      $display("[TB] FAIL rst_mid_after: got rdy=%b data=%h, expected 0001 %h", oReqRdy, oReqData, d);
    end
    step();
    lastData = d;
  endtask

  task automatic test_wrap();
    iReqRead = 4'b0100;
    step();
    iMemRdy = 1'b1;
    step();
    iMemRdy  = 1'b0;
    iReqRead = '0;
    step();
    iReqRead = 4'b1001;
    step();
    nChecks++;
    if (oGrant !== 4'b1000) begin
      nFails++;
      $display("[TB] FAIL wrap_first: got grant=%b, expected 1000", oGrant);
    end
    iMemRdy = 1'b1;
    step();
    iMemRdy = 1'b0;
    nChecks++;
    if (oReqRdy !== 4'b1000) begin
      nFails++;
      $display("[TB] FAIL wrap_first_rdy: got rdy=%b, expected 1000", oReqRdy);
    end
    iReqRead[3] = 1'b0;
    step();
    step();
    nChecks++;
    if (oGrant !== 4'b0001) begin
      nFails++;
      $display("[TB] FAIL wrap_second: got grant=%b, expected 0001", oGrant);
    end
    iMemRdy = 1'b1;
    step();
    iMemRdy  = 1'b0;
    iReqRead = '0;
    step();
  endtask

  task automatic test_random();
    bit pend[NCH];
    bit rdM[NCH];
    bit wrM[NCH];
    logic [AW-1:0] addrM[NCH];
    logic [DW-1:0] wdM[NCH];
    int rrM, w, wt, nStrobe, forced, op, idx;
    bit isWr, expErr;
    logic [DW-1:0] rdData;
    applyReset();
    rrM = 0;
    for (int c = 0; c < NCH; c++) pend[c] = 1'b0;
    for (int t = 0; t < 40; t++) begin
      forced = $urandom_range(0, NCH - 1);
      for (int c = 0; c < NCH; c++) begin
        if (!pend[c] && (c == forced || $urandom_range(0, 1) == 1)) begin
          pend[c]  = 1'b1;
          op       = $urandom_range(0, 2);
          wrM[c]   = (op != 0);
          rdM[c]   = (op != 1);
          addrM[c] = $urandom;
          wdM[c]   = $urandom;
          iReqAddr[c*AW +: AW] = addrM[c];
          iReqData[c*DW +: DW] = wdM[c];
        end
        iReqRead[c]  = pend[c] && rdM[c];
        iReqWrite[c] = pend[c] && wrM[c];
      end
      iMemRdy  = ($urandom_range(0, 1) == 1);
      iMemData = $urandom;
      w = -1;
      for (int i = 0; i < NCH; i++) begin
        idx = (rrM + i) % NCH;
        if (w < 0 && pend[idx]) w = idx;
      end
      isWr    = wrM[w];
      wt      = $urandom_range(0, TO + 2);
      expErr  = (wt >= TO);
      nStrobe = expErr ? TO : wt + 1;
      rdData  = lastData;
      for (int j = 0; j < nStrobe; j++) begin
        step();
        nChecks++;
        if (oGrant !== (NCH'(1) << w) || {oMemRead, oMemWrite} !== {!isWr, isWr} || oBusy !== 1'b1 || oReqRdy !== '0) begin
          nFails++;
          $display("[TB] FAIL rand_access t=%0d j=%0d: got grant=%b rd=%b wr=%b busy=%b rdy=%b, expected ch %0d write=%b",
                   t, j, oGrant, oMemRead, oMemWrite, oBusy, oReqRdy, w, isWr);
        end
        nChecks++;
        if (oMemAddr !== addrM[w] || (isWr && oMemData !== wdM[w])) begin
          nFails++;
          $display("[TB] FAIL rand_addr t=%0d j=%0d: got addr=%h wdata=%h, expected %h %h", t, j, oMemAddr, oMemData, addrM[w], wdM[w]);
        end
        iReqAddr[w*AW +: AW] = $urandom;
        iMemRdy  = !expErr && (j == wt);
        iMemData = $urandom;
        if (iMemRdy && !isWr) rdData = iMemData;
      end
      if (expErr) rdData = '0;
      step();
      nChecks++;
      if (oReqRdy !== (NCH'(1) << w) || oReqErr !== (expErr ? (NCH'(1) << w) : NCH'(0))
          || oReqData !== rdData || {oMemRead, oMemWrite} !== 2'b00) begin
        nFails++;
        $display("[TB] FAIL rand_resp t=%0d: got rdy=%b err=%b data=%h rd=%b wr=%b, expected ch %0d err=%b data=%h",
                 t, oReqRdy, oReqErr, oReqData, oMemRead, oMemWrite, w, expErr, rdData);
      end
      lastData     = rdData;
      pend[w]      = 1'b0;
      iReqRead[w]  = 1'b0;
      iReqWrite[w] = 1'b0;
      rrM = (w + 1) % NCH;
      iMemRdy  = ($urandom_range(0, 1) == 1);
      iMemData = $urandom;
      step();
      nChecks++;
      if (oGrant !== '0 || oReqRdy !== '0 || oBusy !== 1'b0 || oReqData !== lastData) begin
        nFails++;
        $display("[TB] FAIL rand_idle t=%0d: got grant=%b rdy=%b busy=%b data=%h, expected 0 0 0 %h",
                 t, oGrant, oReqRdy, oBusy, oReqData, lastData);
      end
    end
    clearInputs();
  endtask

  // Run every scenario in order, then report
  initial begin
    iRst = 1'b0;
    lastData = '0;
    clearInputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_priority();
    test_timeout();
    test_reset_mid_access();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised N-channel memory arbiter. It lets several requesters share the single processor memory port (oMemAddr/oMemData/iMemData/iMemRdy/oMemRead/oMemWrite), for example instruction fetch, data access and a DMA or second core. It applies round-robin fairness, registers the memory-side signals, and adds an optional wait-state timeout with per-channel error reporting. A channel sees exactly one ready pulse per completed transaction.

## Interface
- NCH, 2: number of requester channels (1..8)
- AW, 32: address width
- DW, 32: data width
- TIMEOUT, 0: maximum cycles spent waiting for iMemRdy; 0 disables the timeout
- iClk  in  1  clock; all logic on the rising edge
- iRst  in  1  reset; synchronous, active-high
- iReqRead  in  NCH  per-channel read request; held until that channel's oReqRdy
- iReqWrite  in  NCH  per-channel write request; held until that channel's oReqRdy
- iReqAddr  in  NCH*AW  channel c occupies bits [c*AW +: AW]
- iReqData  in  NCH*DW  write data; channel c occupies bits [c*DW +: DW]
- oReqData  out  DW  read data, shared by all channels; valid only while oReqRdy is set
- oReqRdy  out  NCH  one-cycle completion pulse, one-hot
- oReqErr  out  NCH  qualifies oReqRdy; 1 means the transaction timed out
- oGrant  out  NCH  one-hot granted channel; 0 when idle
- oBusy  out  1  high in ACCESS and RESP
- oMemAddr  out  AW  registered memory address
- oMemData  out  DW  registered memory write data
- oMemRead  out  1  memory read strobe
- oMemWrite  out  1  memory write strobe
- iMemData  in  DW  memory read data; sampled when iMemRdy=1
- iMemRdy  in  1  memory completion; qualifies iMemData

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - Channel c is requesting if iReqRead[c] or iReqWrite[c] is set.
  - Winner: the first requesting channel found scanning upward from pointer rr, wrapping at NCH-1 back to 0.
  - On a winner: latch g, address, write data and op; go to ACCESS.
  - Op is write if iReqWrite[g], else read. Write wins when both are set.
- **ACCESS**
  - oMemRead or oMemWrite is held high, with oMemAddr/oMemData stable.
  - iMemRdy=1: capture iMemData (read) or nothing (write); err=0; go to RESP.
  - TIMEOUT>0 and the wait counter equals TIMEOUT-1 with iMemRdy=0: err=1, captured data=0; go to RESP.
  - iMemRdy and timeout in the same cycle: iMemRdy wins, err=0.
  - The wait counter clears on ACCESS entry. Its width is $clog2(TIMEOUT+1), minimum 1.
- **RESP**
  - Strobes are low.
  - oReqRdy[g]=1 and oReqErr[g]=err for exactly one cycle.
  - oReqData = captured data. It holds this value afterwards until the next RESP.
  - rr <= (g+1) mod NCH; go to IDLE.
- oGrant = one-hot(g) in ACCESS and RESP; 0 in IDLE.
- Requests arriving while busy are not lost; they are evaluated at the next IDLE cycle.
- A requester must drop its request on the edge ending its RESP cycle. A request still high in IDLE is treated as a new transaction.
- Address and data changes from the granted channel during ACCESS are ignored, because the values are latched.
- NCH=1: rr stays 0; the behaviour is a registered pass-through.

## Timing
- **Reset** (iRst=1 at an edge), effective the next cycle:
  - state=IDLE, rr=0, counter=0.
  - oMemRead=oMemWrite=0, oMemAddr=0, oMemData=0.
  - oReqData=0, oReqRdy=0, oReqErr=0, oGrant=0, oBusy=0.
- **Reset mid-ACCESS or mid-RESP:** the transaction is abandoned. No oReqRdy is issued and the strobes are low the next cycle.
- **Latency**
  - Request sampled in IDLE at cycle 0.
  - Strobe high from cycle 1.
  - iMemRdy seen in cycle k (k≥1) gives oReqRdy in cycle k+1.
  - Minimum is 3 cycles request-to-idle; oReqRdy arrives in cycle 2.
- **Throughput:** one transaction per 3 cycles plus the memory wait states. Strobes always drop for at least one cycle (RESP) between transactions.
- **Timeout:** with TIMEOUT=T, a silent memory gives a strobe high for exactly T cycles, then the error RESP.
- iMemRdy is ignored outside ACCESS.

## Test plan
- **Single read:** NCH=2, channel 0 reads 0x100; memory returns 0xDEADBEEF with iMemRdy in the first ACCESS cycle.
  - oMemRead high one cycle.
  - oReqRdy=2'b01 in cycle 2, oReqData=0xDEADBEEF, oReqErr=0.
- **Round-robin:** channels 0 and 1 hold requests continuously, re-asserting after each oReqRdy; memory has 0 wait.
  - Grant order 0,1,0,1.
  - oReqRdy pulses every 3 cycles and alternates.
- **Write priority and wait states:** channel 1 asserts read and write together, address 0x20, data 0x5A; iMemRdy delayed 4 cycles.
  - oMemWrite high 5 cycles, oMemRead never high.
  - oReqRdy[1] once.
- **Timeout:** TIMEOUT=8, iMemRdy held 0.
  - Strobe high for 8 cycles.
  - oReqRdy[g]=1, oReqErr[g]=1, oReqData=0.
  - Repeat with iMemRdy arriving on the 8th cycle: oReqErr=0.
- **Reset mid-ACCESS:** iRst pulsed on the 2nd ACCESS cycle.
  - All outputs 0 the next cycle; no oReqRdy.
  - rr=0: a subsequent simultaneous request from channels 0 and 2 (NCH=4) grants 0 first.
- **Wrap:** NCH=4, rr=3, channels 0 and 3 requesting.
  - Grant 3, then 0.
